// File: rtl/lif_pkg.sv
// Shared parameters for the leaky integrate-and-fire neuron tile.
package lif_pkg;

    localparam int unsigned WIDTH          = 8;
    localparam int unsigned LEAK_SHIFT     = 3;
    localparam int unsigned THRESHOLD      = 200;
    localparam int unsigned REFRACTORY     = 4;
    // uio_in value that selects the built-in THRESHOLD instead of a runtime one
    localparam int unsigned THR_SEL_DEFAULT = 0;
    localparam int unsigned REFR_W         = $clog2(REFRACTORY + 1);

endpackage : lif_pkg

// File: rtl/lif_core.sv
// Leak/integrate/saturate/compare/refractory datapath for one LIF neuron.
module lif_core
    import lif_pkg::*;
#(
    parameter int unsigned P_WIDTH      = WIDTH,
    parameter int unsigned P_LEAK_SHIFT = LEAK_SHIFT,
    parameter int unsigned P_REFRACTORY = REFRACTORY,
    parameter int unsigned P_REFR_W     = REFR_W
) (
    input  logic               clk,
    input  logic               rst_n,      // active-high asynchronous reset
    input  logic               ena,
    input  logic [P_WIDTH-1:0] current,
    input  logic [P_WIDTH-1:0] thr,
    output logic [P_WIDTH-1:0] u,
    output logic               spike
);

    localparam int unsigned SUM_W = P_WIDTH + 1;

    logic [P_WIDTH-1:0]  r_u;
    logic                r_spike;
    logic [P_REFR_W-1:0] r_refr;

    logic [P_WIDTH-1:0]  w_u_next;
    logic                w_spike_next;
    logic [P_REFR_W-1:0] w_refr_next;

    logic [SUM_W-1:0]    w_sum;
    logic [P_WIDTH-1:0]  w_sat;

    // Leaky integration one bit wider than the datapath so overflow is visible.
    always_comb begin
        w_sum = {1'b0, r_u} - {1'b0, (r_u >> P_LEAK_SHIFT)} + {1'b0, current};
        w_sat = w_sum[SUM_W-1] ? {P_WIDTH{1'b1}} : w_sum[P_WIDTH-1:0];
    end

    // Next-state: refractory hold, fire-and-clear, or accumulate; spike is a one-cycle pulse.
    always_comb begin
        w_u_next     = r_u;
        w_spike_next = 1'b0;
        w_refr_next  = r_refr;
        if (ena) begin
            if (r_refr != '0) begin
                w_u_next    = '0;
                w_refr_next = r_refr - P_REFR_W'(1);
            end else if (w_sat >= thr) begin
                w_u_next     = '0;
                w_spike_next = 1'b1;
                w_refr_next  = P_REFR_W'(P_REFRACTORY);
            end else begin
                w_u_next = w_sat;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_u     <= '0;
            r_spike <= 1'b0;
            r_refr  <= '0;
        end else begin
            r_u     <= w_u_next;
            r_spike <= w_spike_next;
            r_refr  <= w_refr_next;
        end
    end

    assign u     = r_u;
    assign spike = r_spike;

endmodule : lif_core

// File: rtl/seven_segment_seconds.sv
// Tile top: pin mapping and runtime threshold select around one LIF neuron.
module seven_segment_seconds
    import lif_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,      // active-high asynchronous reset despite the name
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [WIDTH-1:0] w_thr;
    logic [WIDTH-1:0] w_u;
    logic             w_spike;
    logic             w_unused_u0;

    // A zero on uio_in falls back to the built-in threshold.
    always_comb begin
        w_thr = (uio_in == WIDTH'(THR_SEL_DEFAULT)) ? WIDTH'(THRESHOLD) : uio_in;
    end

    lif_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .current (ui_in),
        .thr     (w_thr),
        .u       (w_u),
        .spike   (w_spike)
    );

    // Only the upper potential bits fit beside the spike flag.
    assign uo_out      = {w_u[WIDTH-1:1], w_spike};
    assign w_unused_u0 = w_u[0];
    assign uio_out     = '0;
    assign uio_oe      = '0;

endmodule : seven_segment_seconds

// File: tb/tb_seven_segment_seconds.sv
// Directed-vector bench for the LIF neuron tile.
module tb_seven_segment_seconds;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec;
    int n_err;

    seven_segment_seconds dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        rst_n  = 1'b1;
        step();
        rst_n  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        ui_in = 8'd50;
        step();
        step();
        n_vec++;
        if (uo_out !== 8'h5E) begin
            n_err++;
            $display("FAIL reset_pre_state: got %h want %h", uo_out, 8'h5E);
        end
        ui_in = 8'hFF;
        ena   = 1'b1;
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (uo_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_async_uo: got %h want %h", uo_out, 8'h00);
        end
        n_vec++;
        if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_uio: got oe=%h out=%h want 00 00", uio_oe, uio_out);
        end
        step();
        n_vec++;
        if (uo_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_held: got %h want %h", uo_out, 8'h00);
        end
        rst_n = 1'b0;
    endtask

    task automatic test_integrate_fire();
        logic [7:0] exp_u [5];
        exp_u = '{8'd50, 8'd94, 8'd133, 8'd167, 8'd197};
        do_reset();
        ui_in = 8'd50;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (uo_out !== (exp_u[i] & 8'hFE)) begin
                n_err++;
                $display("FAIL integrate_u%0d: got %h want %h", i, uo_out, exp_u[i] & 8'hFE);
            end
        end
        step();
        n_vec++;
        if (uo_out !== 8'h01) begin
            n_err++;
            $display("FAIL integrate_spike: got %h want %h", uo_out, 8'h01);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (uo_out !== 8'h00) begin
                n_err++;
                $display("FAIL refractory_%0d: got %h want %h", i, uo_out, 8'h00);
            end
        end
        step();
        n_vec++;
        if (uo_out !== 8'h32) begin
            n_err++;
            $display("FAIL integrate_restart: got %h want %h", uo_out, 8'h32);
        end
    endtask

    task automatic test_leak_decay();
        logic [7:0] exp_u [4];
        exp_u = '{8'd88, 8'd77, 8'd68, 8'd60};
        do_reset();
        ui_in = 8'd100;
        step();
        n_vec++;
        if (uo_out !== 8'h64) begin
            n_err++;
            $display("FAIL leak_load: got %h want %h", uo_out, 8'h64);
        end
        ui_in = 8'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (uo_out !== (exp_u[i] & 8'hFE)) begin
                n_err++;
                $display("FAIL leak_u%0d: got %h want %h", i, uo_out, exp_u[i] & 8'hFE);
            end
        end
        repeat (30) step();
        n_vec++;
        if (uo_out !== 8'h06) begin
            n_err++;
            $display("FAIL leak_residue: got %h want %h", uo_out, 8'h06);
        end
        repeat (10) step();
        n_vec++;
        if (uo_out !== 8'h06) begin
            n_err++;
            $display("FAIL leak_residue_hold: got %h want %h", uo_out, 8'h06);
        end
    endtask

    task automatic test_saturation_thr();
        do_reset();
        uio_in = 8'd255;
        ui_in  = 8'd255;
        step();
        n_vec++;
        if (uo_out !== 8'h01) begin
            n_err++;
            $display("FAIL sat_fire_first: got %h want %h", uo_out, 8'h01);
        end
        ui_in = 8'd0;
        repeat (4) step();
        ui_in = 8'd200;
        step();
        n_vec++;
        if (uo_out !== 8'hC8) begin
            n_err++;
            $display("FAIL sat_no_fire_200: got %h want %h", uo_out, 8'hC8);
        end
        step();
        n_vec++;
        if (uo_out !== 8'h01) begin
            n_err++;
            $display("FAIL sat_fire_saturated: got %h want %h", uo_out, 8'h01);
        end
        step();
        n_vec++;
        if (uo_out !== 8'h00) begin
            n_err++;
            $display("FAIL sat_no_back_to_back: got %h want %h", uo_out, 8'h00);
        end
    endtask

    task automatic test_enable_gating();
        logic [7:0] exp_u [3];
        exp_u = '{8'd133, 8'd167, 8'd197};
        do_reset();
        ui_in = 8'd50;
        step();
        step();
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if (uo_out !== 8'h5E) begin
                n_err++;
                $display("FAIL ena_frozen_%0d: got %h want %h", i, uo_out, 8'h5E);
            end
        end
        ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (uo_out !== (exp_u[i] & 8'hFE)) begin
                n_err++;
                $display("FAIL ena_resume_u%0d: got %h want %h", i, uo_out, exp_u[i] & 8'hFE);
            end
        end
        step();
        n_vec++;
        if (uo_out !== 8'h01) begin
            n_err++;
            $display("FAIL ena_resume_spike: got %h want %h", uo_out, 8'h01);
        end
    endtask

    task automatic test_thr_change();
        do_reset();
        ui_in = 8'd50;
        step();
        step();
        n_vec++;
        if (uo_out !== 8'h5E) begin
            n_err++;
            $display("FAIL thr_pre: got %h want %h", uo_out, 8'h5E);
        end
        uio_in = 8'd100;
        step();
        n_vec++;
        if (uo_out !== 8'h01) begin
            n_err++;
            $display("FAIL thr_change_fire: got %h want %h", uo_out, 8'h01);
        end
    endtask

    task automatic test_reset_mid_refractory();
        do_reset();
        ui_in = 8'd255;
        step();
        n_vec++;
        if (uo_out !== 8'h01) begin
            n_err++;
            $display("FAIL rmr_spike: got %h want %h", uo_out, 8'h01);
        end
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (uo_out !== 8'h00) begin
            n_err++;
            $display("FAIL rmr_async: got %h want %h", uo_out, 8'h00);
        end
        step();
        rst_n = 1'b0;
        ui_in = 8'd50;
        step();
        n_vec++;
        if (uo_out !== 8'h32) begin
            n_err++;
            $display("FAIL rmr_resume: got %h want %h", uo_out, 8'h32);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        test_reset();
        test_integrate_fire();
        test_leak_decay();
        test_saturation_thr();
        test_enable_gating();
        test_thr_change();
        test_reset_mid_refractory();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seven_segment_seconds
